// File: rtl/data_controller_rr.sv
// LSU <-> global-memory data controller: grants one core per transaction and fans its lanes onto the memory lanes.
// Optional build macro DATA_CTRL_RR_ARB_EN selects round-robin arbitration; otherwise the lowest core index wins.
module data_controller_rr #(
  parameter int NUM_CORES      = 4,
  parameter int MAX_THREADS    = 4,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 16
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic [NUM_CORES*MAX_THREADS-1:0]                         read_req_addr_val,
  input  logic [NUM_CORES*MAX_THREADS-1:0][MEM_ADDR_WIDTH-1:0]     read_req_addr,
  output logic [NUM_CORES*MAX_THREADS-1:0]                         read_req_rdy,
  output logic [NUM_CORES*MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0]     read_resp_data,
  output logic [NUM_CORES*MAX_THREADS-1:0]                         read_resp_data_val,
  input  logic [NUM_CORES*MAX_THREADS-1:0]                         read_resp_rdy,
  input  logic [NUM_CORES*MAX_THREADS-1:0]                         write_req_val,
  input  logic [NUM_CORES*MAX_THREADS-1:0][MEM_ADDR_WIDTH-1:0]     write_req_addr,
  input  logic [NUM_CORES*MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0]     write_req_data,
  output logic [NUM_CORES*MAX_THREADS-1:0]                         write_req_rdy,
  output logic [NUM_CORES*MAX_THREADS-1:0]                         write_resp_val,
  output logic [MAX_THREADS-1:0]                                   mem2read_req_addr_val,
  output logic [MAX_THREADS-1:0][MEM_ADDR_WIDTH-1:0]               mem2read_req_addr,
  input  logic [MAX_THREADS-1:0]                                   mem2read_req_rdy,
  input  logic [MAX_THREADS-1:0]                                   mem2read_resp_data_val,
  input  logic [MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0]               mem2read_resp_data,
  output logic [MAX_THREADS-1:0]                                   mem2read_resp_rdy,
  output logic [MAX_THREADS-1:0]                                   mem2write_req_val,
  output logic [MAX_THREADS-1:0][MEM_ADDR_WIDTH-1:0]               mem2write_req_addr,
  output logic [MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0]               mem2write_req_data,
  input  logic [MAX_THREADS-1:0]                                   mem2write_req_rdy,
  input  logic [MAX_THREADS-1:0]                                   mem2write_resp_val,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0]     compute_unit,
  output logic                                                     busy
);

  localparam int T  = MAX_THREADS;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          op_wr_q, op_wr_d;
  logic [T-1:0]  mask_q, mask_d;
  logic [T-1:0]  issued_q, issued_d;
  logic [T-1:0]  got_q, got_d;
  logic [CW-1:0] core_q, core_d;

  logic [T-1:0][MEM_ADDR_WIDTH-1:0] addr_q;
  logic [T-1:0][MEM_DATA_WIDTH-1:0] wdata_q;
  logic [T-1:0][MEM_DATA_WIDTH-1:0] rdata_q;

  logic [NUM_CORES-1:0] core_req;
  logic                 found;
  logic [CW-1:0]        win;
  logic [CW-1:0]        start_w;
  int                   arb_idx;
  logic                 grant;
  logic [T-1:0]         win_rd, win_wr;
  logic                 win_is_rd;

  logic                 active;
  logic [T-1:0]         req_fire;
  logic [T-1:0]         rd_hit, wr_hit, lane_done;
  logic [T-1:0]         lane_rsp_rdy;

  // Arbiter: scan cores starting at start_w, first requester wins
  always_comb begin
    core_req = '0;
    found    = 1'b0;
    win      = '0;
    arb_idx  = 0;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_req[c] = (|read_req_addr_val[c*T +: T]) | (|write_req_val[c*T +: T]);
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      arb_idx = (int'(start_w) + i) % NUM_CORES;
      if (!found && core_req[arb_idx]) begin
        found = 1'b1;
        win   = CW'(arb_idx);
      end
    end
  end

`ifdef DATA_CTRL_RR_ARB_EN
  logic [CW-1:0] start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= '0;
    end else if (grant) begin
      start_q <= (int'(win) == NUM_CORES - 1) ? '0 : win + CW'(1);
    end
  end

  assign start_w = start_q;
`else
  assign start_w = '0;
`endif

  assign grant     = (state_q == S_IDLE) && found;
  assign win_rd    = read_req_addr_val[int'(win)*T +: T];
  assign win_wr    = write_req_val[int'(win)*T +: T];
  assign win_is_rd = |win_rd;

  assign active       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign lane_rsp_rdy = read_resp_rdy[int'(core_q)*T +: T];

  // Memory side: issue lanes independently, accept responses from ISSUE onwards
  always_comb begin
    mem2read_req_addr_val = '0;
    mem2write_req_val     = '0;
    if (state_q == S_ISSUE) begin
      if (op_wr_q) mem2write_req_val     = mask_q & ~issued_q;
      else         mem2read_req_addr_val = mask_q & ~issued_q;
    end
    mem2read_resp_rdy = (active && !op_wr_q) ? (mask_q & ~got_q) : '0;
    for (int t = 0; t < T; t++) begin
      mem2read_req_addr[t]  = mem2read_req_addr_val[t] ? addr_q[t]  : '0;
      mem2write_req_addr[t] = mem2write_req_val[t]     ? addr_q[t]  : '0;
      mem2write_req_data[t] = mem2write_req_val[t]     ? wdata_q[t] : '0;
    end
  end

  assign req_fire  = (mem2read_req_addr_val & mem2read_req_rdy) |
                     (mem2write_req_val & mem2write_req_rdy);
  assign rd_hit    = mem2read_resp_data_val & mem2read_resp_rdy;
  assign wr_hit    = (active && op_wr_q) ? (mem2write_resp_val & mask_q & ~got_q) : '0;
  assign lane_done = op_wr_q ? wr_hit : rd_hit;

  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    mask_d   = mask_q;
    issued_d = issued_q;
    got_d    = got_q;
    core_d   = core_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_ISSUE;
          op_wr_d  = ~win_is_rd;
          mask_d   = win_is_rd ? win_rd : win_wr;
          issued_d = '0;
          got_d    = '0;
          core_d   = win;
        end
      end
      S_ISSUE: begin
        issued_d = issued_q | req_fire;
        got_d    = got_q | lane_done;
        if ((issued_d & mask_q) == mask_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        got_d = got_q | lane_done;
        if ((got_d & mask_q) == mask_q) state_d = S_DELIVER;
      end
      default: begin
        // Read lanes retire one by one as the LSU accepts; writes just pulse once
        if (op_wr_q) begin
          got_d   = '0;
          state_d = S_IDLE;
        end else begin
          got_d = got_q & ~lane_rsp_rdy;
          if (got_d == '0) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_wr_q  <= 1'b0;
      mask_q   <= '0;
      issued_q <= '0;
      got_q    <= '0;
      core_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_wr_q  <= op_wr_d;
      mask_q   <= mask_d;
      issued_q <= issued_d;
      got_q    <= got_d;
      core_q   <= core_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      for (int t = 0; t < T; t++) begin
        addr_q[t]  <= win_is_rd ? read_req_addr[int'(win)*T + t] : write_req_addr[int'(win)*T + t];
        wdata_q[t] <= write_req_data[int'(win)*T + t];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      for (int t = 0; t < T; t++) begin
        if (rd_hit[t]) rdata_q[t] <= mem2read_resp_data[t];
      end
    end
  end

  // LSU side: only the granted core's lanes ever see rdy/valid/data
  always_comb begin
    read_req_rdy       = '0;
    write_req_rdy      = '0;
    read_resp_data_val = '0;
    read_resp_data     = '0;
    write_resp_val     = '0;
    if (grant) begin
      if (win_is_rd) read_req_rdy[int'(win)*T +: T]  = win_rd;
      else           write_req_rdy[int'(win)*T +: T] = win_wr;
    end
    if (state_q == S_DELIVER) begin
      for (int t = 0; t < T; t++) begin
        if (op_wr_q) begin
          write_resp_val[int'(core_q)*T + t] = mask_q[t];
        end else begin
          read_resp_data_val[int'(core_q)*T + t] = got_q[t];
          read_resp_data[int'(core_q)*T + t]     = got_q[t] ? rdata_q[t] : '0;
        end
      end
    end
  end

  assign compute_unit = core_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_controller_rr.sv
// Directed bench for data_controller_rr with a small lane-level memory responder driven from the stimulus thread.
module tb_data_controller_rr;
  localparam int NC = 4;
  localparam int T  = 4;
  localparam int L  = NC*T;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [L-1:0]         read_req_addr_val;
  logic [L-1:0][AW-1:0] read_req_addr;
  logic [L-1:0]         read_req_rdy;
  logic [L-1:0][DW-1:0] read_resp_data;
  logic [L-1:0]         read_resp_data_val;
  logic [L-1:0]         read_resp_rdy;
  logic [L-1:0]         write_req_val;
  logic [L-1:0][AW-1:0] write_req_addr;
  logic [L-1:0][DW-1:0] write_req_data;
  logic [L-1:0]         write_req_rdy;
  logic [L-1:0]         write_resp_val;
  logic [T-1:0]         m_rd_req_val;
  logic [T-1:0][AW-1:0] m_rd_req_addr;
  logic [T-1:0]         m_rd_req_rdy;
  logic [T-1:0]         m_rd_resp_val;
  logic [T-1:0][DW-1:0] m_rd_resp_data;
  logic [T-1:0]         m_rd_resp_rdy;
  logic [T-1:0]         m_wr_req_val;
  logic [T-1:0][AW-1:0] m_wr_req_addr;
  logic [T-1:0][DW-1:0] m_wr_req_data;
  logic [T-1:0]         m_wr_req_rdy;
  logic [T-1:0]         m_wr_resp_val;
  logic [1:0]           compute_unit;
  logic                 busy;

  data_controller_rr #(
    .NUM_CORES(NC), .MAX_THREADS(T), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .read_req_addr_val(read_req_addr_val), .read_req_addr(read_req_addr),
    .read_req_rdy(read_req_rdy), .read_resp_data(read_resp_data),
    .read_resp_data_val(read_resp_data_val), .read_resp_rdy(read_resp_rdy),
    .write_req_val(write_req_val), .write_req_addr(write_req_addr),
    .write_req_data(write_req_data), .write_req_rdy(write_req_rdy),
    .write_resp_val(write_resp_val),
    .mem2read_req_addr_val(m_rd_req_val), .mem2read_req_addr(m_rd_req_addr),
    .mem2read_req_rdy(m_rd_req_rdy), .mem2read_resp_data_val(m_rd_resp_val),
    .mem2read_resp_data(m_rd_resp_data), .mem2read_resp_rdy(m_rd_resp_rdy),
    .mem2write_req_val(m_wr_req_val), .mem2write_req_addr(m_wr_req_addr),
    .mem2write_req_data(m_wr_req_data), .mem2write_req_rdy(m_wr_req_rdy),
    .mem2write_resp_val(m_wr_resp_val),
    .compute_unit(compute_unit), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]        mem [256];
  logic [T-1:0]         pend;
  logic [T-1:0][DW-1:0] pdata;
  logic                 hold;
  int                   stall [T];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic outs_zero();
    return (read_req_rdy == '0) && (read_resp_data == '0) && (read_resp_data_val == '0) &&
           (write_req_rdy == '0) && (write_resp_val == '0) && (m_rd_req_val == '0) &&
           (m_rd_req_addr == '0) && (m_rd_resp_rdy == '0) && (m_wr_req_val == '0) &&
           (m_wr_req_addr == '0) && (m_wr_req_data == '0) && (compute_unit == '0) && !busy;
  endfunction

  // One clock: memory sees this cycle's handshakes, answers in the next cycle
  task automatic tick();
    logic [T-1:0]         rf, wf, acc;
    logic [T-1:0][AW-1:0] ra, wa;
    logic [T-1:0][DW-1:0] wd;
    #1;
    rf  = m_rd_req_val & m_rd_req_rdy;
    ra  = m_rd_req_addr;
    wf  = m_wr_req_val & m_wr_req_rdy;
    wa  = m_wr_req_addr;
    wd  = m_wr_req_data;
    acc = m_rd_resp_val & m_rd_resp_rdy;
    @(posedge clk);
    #1;
    for (int t = 0; t < T; t++) begin
      if (acc[t]) pend[t] = 1'b0;
      if (rf[t]) begin
        pend[t]  = 1'b1;
        pdata[t] = mem[ra[t]];
      end
      if (wf[t]) mem[wa[t]] = wd[t];
      if (stall[t] != 0) stall[t] = stall[t] - 1;
      m_rd_req_rdy[t] = (stall[t] == 0);
    end
    m_rd_resp_val  = hold ? '0 : pend;
    m_rd_resp_data = pdata;
    m_wr_resp_val  = wf;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants [4];
    int exp_g  [4];
    int gcount;
    int bad;
    int wk;
`ifdef DATA_CTRL_RR_ARB_EN
    exp_g = '{0, 3, 0, 3};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    pend = '0; pdata = '0; hold = 1'b0;
    for (int t = 0; t < T; t++) stall[t] = 0;
    reset = 1'b1;
    read_req_addr_val = '0; read_req_addr = '0; read_resp_rdy = '0;
    write_req_val = '0; write_req_addr = '0; write_req_data = '0;
    m_rd_req_rdy = '1; m_rd_resp_val = '0; m_rd_resp_data = '0;
    m_wr_req_rdy = '1; m_wr_resp_val = '0;

    // Reset state
    tick(); tick();
    check("reset_outs_zero", 64'(outs_zero()), 64'd1);
    reset = 1'b0;
    tick();

    // Core 1 reads lanes 0-3 at 0x10..0x13
    read_req_addr_val = 16'h00F0;
    for (int t = 0; t < T; t++) read_req_addr[4+t] = 8'h10 + 8'(t);
    #1;
    check("rd_req_rdy_core1", 64'(read_req_rdy), 64'h00F0);
    check("rd_idle_not_busy", 64'(busy), 64'd0);
    tick();
    read_req_addr_val = '0;
    #1;
    check("rd_issue_val", 64'(m_rd_req_val), 64'hF);
    check("rd_issue_addr2", 64'(m_rd_req_addr[2]), 64'h12);
    check("rd_compute_unit", 64'(compute_unit), 64'd1);
    tick();
    check("rd_wait_resp_rdy", 64'(m_rd_resp_rdy), 64'hF);
    check("rd_wait_no_resp", 64'(read_resp_data_val), 64'h0);
    tick();
    check("rd_resp_val_n3", 64'(read_resp_data_val), 64'h00F0);
    check("rd_resp_data6", 64'(read_resp_data[6]), 64'hA012);
    check("rd_resp_data4", 64'(read_resp_data[4]), 64'hA010);
    read_resp_rdy = 16'h0030;
    #1;
    tick();
    check("rd_partial_drop", 64'(read_resp_data_val), 64'h00C0);
    check("rd_partial_data7", 64'(read_resp_data[7]), 64'hA013);
    read_resp_rdy = 16'h00F0;
    #1;
    tick();
    read_resp_rdy = '0;
    #1;
    check("rd_done_idle", {62'd0, busy, |read_resp_data_val}, 64'd0);

    // Core 2 writes lanes 0 and 2
    write_req_val = 16'h0500;
    write_req_addr[8]  = 8'h20; write_req_data[8]  = 16'h1234;
    write_req_addr[10] = 8'h22; write_req_data[10] = 16'hBEEF;
    #1;
    check("wr_req_rdy_core2", 64'(write_req_rdy), 64'h0500);
    check("wr_no_rd_rdy", 64'(read_req_rdy), 64'h0);
    tick();
    write_req_val = '0;
    #1;
    check("wr_issue_val", 64'(m_wr_req_val), 64'b0101);
    check("wr_issue_addr0", 64'(m_wr_req_addr[0]), 64'h20);
    check("wr_issue_data2", 64'(m_wr_req_data[2]), 64'hBEEF);
    tick();
    check("wr_wait_no_resp", 64'(write_resp_val), 64'h0);
    tick();
    check("wr_resp_pulse", 64'(write_resp_val), 64'h0500);
    tick();
    check("wr_resp_single", {48'd0, write_resp_val}, 64'h0);
    check("wr_idle", 64'(busy), 64'd0);
    check("wr_mem_22", 64'(mem[8'h22]), 64'hBEEF);
    check("wr_mem_20", 64'(mem[8'h20]), 64'h1234);

    // Cores 0 and 3 both keep reading, arbitration order
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_resp_rdy = '1;
    read_req_addr_val = 16'h1001;
    read_req_addr[0] = 8'h00; read_req_addr[12] = 8'h30;
    #1;
    gcount = 0;
    for (int k = 0; k < 40 && gcount < 4; k++) begin
      if (read_req_rdy != '0) begin
        grants[gcount] = read_req_rdy[12] ? 3 : (read_req_rdy[0] ? 0 : 7);
        gcount++;
      end
      tick();
    end
    read_req_addr_val = '0;
    check("arb_grant_count", 64'(gcount), 64'd4);
    for (int g = 0; g < 4; g++) check($sformatf("arb_grant%0d", g), 64'(grants[g]), 64'(exp_g[g]));
    wk = 0;
    while (busy && wk < 10) begin
      tick();
      wk++;
    end
    check("arb_drained", 64'(busy), 64'd0);
    read_resp_rdy = '0;

    // Lane 1 memory stall
    read_req_addr_val = 16'h000F;
    for (int t = 0; t < T; t++) read_req_addr[t] = 8'h40 + 8'(t);
    stall[1] = 6;
    m_rd_req_rdy[1] = 1'b0;
    #1;
    check("stall_req_rdy", 64'(read_req_rdy), 64'h000F);
    tick();
    read_req_addr_val = '0;
    #1;
    check("stall_issue_all", 64'(m_rd_req_val), 64'hF);
    tick();
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (m_rd_req_val !== 4'b0010 || m_rd_req_addr[1] !== 8'h41 || read_resp_data_val !== '0) bad++;
      tick();
    end
    check("stall_lane1_held", 64'(bad), 64'd0);
    check("stall_lane1_last", 64'(m_rd_req_val), 64'b0010);
    tick();
    check("stall_wait_no_deliver", 64'(read_resp_data_val), 64'h0);
    tick();
    check("stall_deliver_val", 64'(read_resp_data_val), 64'h000F);
    check("stall_deliver_d1", 64'(read_resp_data[1]), 64'hA041);
    check("stall_deliver_d3", 64'(read_resp_data[3]), 64'hA043);
    read_resp_rdy = 16'h000F;
    #1;
    tick();
    read_resp_rdy = '0;
    #1;
    check("stall_idle", 64'(busy), 64'd0);

    // Core 0 read and write together: read first
    read_req_addr_val = 16'h0001; read_req_addr[0] = 8'h50;
    write_req_val = 16'h0002; write_req_addr[1] = 8'h51; write_req_data[1] = 16'h5A5A;
    read_resp_rdy = '1;
    #1;
    check("rw_read_first", 64'(read_req_rdy), 64'h0001);
    check("rw_write_waits", 64'(write_req_rdy), 64'h0);
    tick();
    read_req_addr_val = '0;
    #1;
    wk = 1;
    while (write_req_rdy == '0 && wk < 10) begin
      tick();
      wk++;
    end
    check("rw_write_cycle", 64'(wk), 64'd4);
    check("rw_write_rdy", 64'(write_req_rdy), 64'h0002);
    tick();
    write_req_val = '0;
    #1;
    tick(); tick();
    check("rw_write_resp", 64'(write_resp_val), 64'h0002);
    tick();
    check("rw_mem_51", 64'(mem[8'h51]), 64'h5A5A);
    check("rw_idle", 64'(busy), 64'd0);
    read_resp_rdy = '0;

    // Reset while waiting on memory
    hold = 1'b1;
    read_req_addr_val = 16'h1000; read_req_addr[12] = 8'h60;
    #1;
    tick();
    read_req_addr_val = '0;
    #1;
    tick();
    check("rst_in_wait_busy", 64'(busy), 64'd1);
    check("rst_in_wait_rdy", 64'(m_rd_resp_rdy), 64'h1);
    reset = 1'b1;
    #1;
    tick();
    check("rst_mid_outs_zero", 64'(outs_zero()), 64'd1);
    reset = 1'b0;
    hold = 1'b0;
    #1;
    tick();
    check("rst_late_resp_present", 64'(m_rd_resp_val), 64'h1);
    check("rst_late_resp_ignored", 64'(outs_zero()), 64'd1);
    tick();
    check("rst_late_resp_still_idle", 64'(outs_zero()), 64'd1);
    pend = '0;
    m_rd_resp_val = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
